// File: rtl/nanov_instr_loader_if.sv
// Bundle of serial-input, CPU handshake and status signals for nanov_instr_loader.
// master = loader side, slave = CPU / serial source side.
interface nanov_instr_loader_if #(
   parameter int WORD_W = 32
);
   logic              si;
   logic              si_valid;
   logic              sync;
   logic [WORD_W-1:0] instr;
   logic              instr_valid;
   logic              instr_ready;
   logic              busy;
   logic              overrun;
   logic              parity_err;
   logic              err_clr;

   modport master (
      input  si, si_valid, sync, instr_ready, err_clr,
      output instr, instr_valid, busy, overrun, parity_err
   );

   modport slave (
      output si, si_valid, sync, instr_ready, err_clr,
      input  instr, instr_valid, busy, overrun, parity_err
   );
endinterface

// File: rtl/nanov_instr_loader.sv
// Serial-to-parallel instruction loader: frames MSB-first bits into words, double-buffers
// them and hands them to the CPU over valid/ready. Optional odd parity via INSTR_PARITY_EN.
module nanov_instr_loader #(
   parameter int WORD_W = 32
) (
   input logic                  cpu_clk,
   input logic                  rst,
   nanov_instr_loader_if.master bus
);

`ifdef INSTR_PARITY_EN
   localparam int FRAME_LEN = WORD_W + 1;
   // The shift register keeps the full word; the parity bit is checked, not stored.
   localparam int SH_W      = WORD_W;
`else
   localparam int FRAME_LEN = WORD_W;
   // The final bit is taken straight from si, so only WORD_W-1 bits need storing.
   localparam int SH_W      = WORD_W - 1;
`endif

   localparam int              CNT_W    = $clog2(FRAME_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

   logic [SH_W-1:0]   shreg_reg, shreg_next;
   logic [SH_W-1:0]   shifted;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [WORD_W-1:0] instr_reg, instr_next;
   logic              valid_reg, valid_next;
   logic              busy_reg;
   logic              overrun_reg, overrun_next;
   logic              perr_reg, perr_next;

   logic [WORD_W-1:0] word_done;
   logic              frame_end;
   logic              par_ok;
   logic              holding_free;
   logic              load;
   logic              ovr_set;
   logic              perr_set;

   // One-bit left shift with si entering at the bottom.
   assign shifted[0] = bus.si;
   generate
      for (genvar gi = 1; gi < SH_W; gi++) begin : g_shift
         assign shifted[gi] = shreg_reg[gi-1];
      end
   endgenerate

   // A sync cycle restarts the frame, so it can never be a final bit (FRAME_LEN >= 2).
   assign frame_end = bus.si_valid && !bus.sync && (cnt_reg == CNT_LAST);

`ifdef INSTR_PARITY_EN
   logic par_reg, par_next;

   assign word_done = shreg_reg;
   assign par_ok    = par_reg ^ bus.si;

   always_comb begin
      par_next = par_reg;
      if (bus.sync)
         par_next = bus.si_valid & bus.si;
      else if (bus.si_valid)
         par_next = frame_end ? 1'b0 : (par_reg ^ bus.si);
   end

   always_ff @(posedge cpu_clk or posedge rst) begin
      if (rst)
         par_reg <= 1'b0;
      else
         par_reg <= par_next;
   end

   always_ff @(posedge cpu_clk or posedge rst) begin
      if (rst)
         perr_reg <= 1'b0;
      else
         perr_reg <= perr_next;
   end

   always_comb begin
      perr_next = perr_reg;
      if (perr_set)
         perr_next = 1'b1;
      else if (bus.err_clr)
         perr_next = 1'b0;
   end
`else
   assign word_done = {shreg_reg, bus.si};
   assign par_ok    = 1'b1;

   always_comb begin
      perr_next = 1'b0;
   end

   always_ff @(posedge cpu_clk or posedge rst) begin
      if (rst)
         perr_reg <= 1'b0;
      else
         perr_reg <= perr_next;
   end
`endif

   assign holding_free = !valid_reg || bus.instr_ready;
   assign load         = frame_end && par_ok && holding_free;
   assign ovr_set      = frame_end && par_ok && !holding_free;
   assign perr_set     = frame_end && !par_ok;

   always_comb begin
      shreg_next = shreg_reg;
      cnt_next   = cnt_reg;
      if (bus.sync) begin
         shreg_next = SH_W'(bus.si_valid & bus.si);
         cnt_next   = bus.si_valid ? CNT_W'(1) : '0;
      end else if (bus.si_valid) begin
`ifdef INSTR_PARITY_EN
         // The parity bit must not push data bits out of the register.
         if (!frame_end)
            shreg_next = shifted;
`else
         shreg_next = shifted;
`endif
         cnt_next = frame_end ? '0 : cnt_reg + CNT_W'(1);
      end
   end

   always_comb begin
      instr_next   = instr_reg;
      valid_next   = valid_reg;
      overrun_next = overrun_reg;
      if (load) begin
         instr_next = word_done;
         valid_next = 1'b1;
      end else if (valid_reg && bus.instr_ready) begin
         valid_next = 1'b0;
      end
      if (ovr_set)
         overrun_next = 1'b1;
      else if (bus.err_clr)
         overrun_next = 1'b0;
   end

   always_ff @(posedge cpu_clk or posedge rst) begin
      if (rst) begin
         shreg_reg   <= '0;
         cnt_reg     <= '0;
         instr_reg   <= '0;
         valid_reg   <= 1'b0;
         busy_reg    <= 1'b0;
         overrun_reg <= 1'b0;
      end else begin
         shreg_reg   <= shreg_next;
         cnt_reg     <= cnt_next;
         instr_reg   <= instr_next;
         valid_reg   <= valid_next;
         busy_reg    <= (cnt_next != '0);
         overrun_reg <= overrun_next;
      end
   end

   assign bus.instr       = instr_reg;
   assign bus.instr_valid = valid_reg;
   assign bus.busy        = busy_reg;
   assign bus.overrun     = overrun_reg;
   assign bus.parity_err  = perr_reg;

endmodule

// File: tb/tb_nanov_instr_loader.sv
// Bench for nanov_instr_loader: directed scenarios plus random traffic against a
// frame-level reference model. Build with +define+INSTR_PARITY_EN for the parity variant.
module tb_nanov_instr_loader;

   localparam int W = 32;
`ifdef INSTR_PARITY_EN
   localparam int F   = W + 1;
   localparam bit PAR = 1'b1;
`else
   localparam int F   = W;
   localparam bit PAR = 1'b0;
`endif

   logic cpu_clk;
   logic rst;

   nanov_instr_loader_if #(.WORD_W(W)) bus ();

   nanov_instr_loader #(.WORD_W(W)) dut (
      .cpu_clk (cpu_clk),
      .rst     (rst),
      .bus     (bus)
   );

   initial cpu_clk = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   int total = 0;
   int bad   = 0;

   // Reference model: bits gathered so far in the frame and the CPU-visible state.
   int         m_cnt;
   logic [W-1:0] m_acc;
   bit         m_par;
   logic [W-1:0] m_hold;
   bit         m_valid, m_ovr, m_perr;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      m_cnt = 0; m_acc = '0; m_par = 0;
      m_hold = '0; m_valid = 0; m_ovr = 0; m_perr = 0;
   endtask

   function automatic logic fbit(input logic [W-1:0] w, input int i, input bit badp);
      if (i < W) return w[W-1-i];
      return (~^w) ^ badp;
   endfunction

   task automatic check_outputs();
      chk("instr",      bus.instr,       m_hold);
      chk("valid",      bus.instr_valid, m_valid);
      chk("busy",       bus.busy,        m_cnt != 0);
      chk("overrun",    bus.overrun,     m_ovr);
      chk("parity_err", bus.parity_err,  m_perr);
   endtask

   // One clock: drive inputs, advance the model, then compare just after the edge.
   task automatic cyc(input logic s, input logic v, input logic sy, input logic rd, input logic ec);
      bit loaded, set_o, set_p;
      loaded = 0; set_o = 0; set_p = 0;
      bus.si = s; bus.si_valid = v; bus.sync = sy; bus.instr_ready = rd; bus.err_clr = ec;
      if (sy) begin
         m_cnt = 0; m_acc = '0; m_par = 0;
      end
      if (v) begin
         if (m_cnt < W) m_acc = {m_acc[W-2:0], s};
         m_par = m_par ^ s;
         m_cnt++;
         if (m_cnt == F) begin
            if (PAR && !m_par) set_p = 1;
            else if (!m_valid || rd) begin
               m_hold = m_acc;
               loaded = 1;
            end else set_o = 1;
            m_cnt = 0; m_acc = '0; m_par = 0;
         end
      end
      if (loaded) m_valid = 1;
      else if (m_valid && rd) m_valid = 0;
      if (set_o) m_ovr = 1; else if (ec) m_ovr = 0;
      if (set_p) m_perr = 1; else if (ec) m_perr = 0;
      @(posedge cpu_clk);
      #1;
      check_outputs();
   endtask

   task automatic send_frame(input logic [W-1:0] w, input int gap, input logic rd_mid,
                             input logic rd_last, input logic ec_last, input bit badp);
      for (int i = 0; i < F; i++) begin
         for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'b0, rd_mid, 1'b0);
         if (i == F - 1) cyc(fbit(w, i, badp), 1'b1, 1'b0, rd_last, ec_last);
         else            cyc(fbit(w, i, badp), 1'b1, 1'b0, rd_mid, 1'b0);
      end
   endtask

   task automatic async_reset();
      bus.si = 0; bus.si_valid = 0; bus.sync = 0; bus.instr_ready = 0; bus.err_clr = 0;
      rst = 1'b1;
      #1;
      model_clear();
      chk("rst_instr",   bus.instr,       '0);
      chk("rst_valid",   bus.instr_valid, 0);
      chk("rst_busy",    bus.busy,        0);
      chk("rst_overrun", bus.overrun,     0);
      chk("rst_perr",    bus.parity_err,  0);
      @(negedge cpu_clk);
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] w;
      rst = 1'b1;
      bus.si = 0; bus.si_valid = 0; bus.sync = 0; bus.instr_ready = 0; bus.err_clr = 0;
      model_clear();
      repeat (2) @(posedge cpu_clk);
      #1;
      check_outputs();
      @(negedge cpu_clk);
      rst = 1'b0;

      // Basic load, ready held high.
      send_frame(32'h0000_0013, 0, 1'b1, 1'b1, 1'b0, 0);
      chk("basic_instr", bus.instr, 32'h0000_0013);
      chk("basic_valid", bus.instr_valid, 1);
      chk("basic_busy",  bus.busy, 0);
      cyc(0, 0, 0, 1, 0);
      chk("basic_one_cycle", bus.instr_valid, 0);

      // Back-pressure causing overrun, then a load freed by a same-cycle transfer.
      send_frame(32'h1234_5678, 0, 1'b0, 1'b0, 1'b0, 0);
      chk("bp_valid", bus.instr_valid, 1);
      send_frame(32'hDEAD_BEEF, 0, 1'b0, 1'b0, 1'b0, 0);
      chk("ovr_flag",  bus.overrun, 1);
      chk("ovr_instr", bus.instr, 32'h1234_5678);
      cyc(0, 0, 0, 0, 1);
      chk("ovr_clr", bus.overrun, 0);
      send_frame(32'hDEAD_BEEF, 0, 1'b0, 1'b1, 1'b0, 0);
      chk("swap_instr", bus.instr, 32'hDEAD_BEEF);
      chk("swap_valid", bus.instr_valid, 1);
      chk("swap_ovr",   bus.overrun, 0);
      cyc(0, 0, 0, 1, 0);

      // Sync mid-word with a coincident first bit.
      for (int i = 0; i < 10; i++) cyc(1'($urandom_range(1, 0)), 1, 0, 1, 0);
      w = 32'h0010_0093;
      cyc(fbit(w, 0, 0), 1, 1, 1, 0);
      for (int i = 1; i < F; i++) cyc(fbit(w, i, 0), 1, 0, 1, 0);
      chk("sync_instr", bus.instr, 32'h0010_0093);
      chk("sync_valid", bus.instr_valid, 1);
      cyc(0, 0, 0, 1, 0);
      chk("sync_no_extra", bus.instr_valid, 0);

      // Gapped input: one valid bit every third cycle.
      send_frame(32'hA5A5_A5A5, 2, 1'b1, 1'b1, 1'b0, 0);
      chk("gap_instr", bus.instr, 32'hA5A5_A5A5);
      chk("gap_valid", bus.instr_valid, 1);
      cyc(0, 0, 0, 1, 0);

      // Asynchronous reset mid-word, then a clean frame.
      for (int i = 0; i < 16; i++) cyc(1'($urandom_range(1, 0)), 1, 0, 1, 0);
      chk("mid_busy", bus.busy, 1);
      async_reset();
      send_frame(32'hCAFE_F00D, 0, 1'b1, 1'b1, 1'b0, 0);
      chk("post_rst_instr", bus.instr, 32'hCAFE_F00D);
      cyc(0, 0, 0, 1, 0);

      // Overrun coincident with err_clr: set wins.
      send_frame(32'h1111_1111, 0, 1'b0, 1'b0, 1'b0, 0);
      send_frame(32'h2222_2222, 0, 1'b0, 1'b0, 1'b1, 0);
      chk("ovr_vs_clr", bus.overrun, 1);
      chk("ovr_vs_clr_instr", bus.instr, 32'h1111_1111);
      cyc(0, 0, 0, 1, 1);
      chk("ovr_cleared", bus.overrun, 0);

`ifdef INSTR_PARITY_EN
      send_frame(32'h0000_0001, 0, 1'b1, 1'b1, 1'b0, 0);
      chk("par_good_valid", bus.instr_valid, 1);
      chk("par_good_instr", bus.instr, 32'h0000_0001);
      cyc(0, 0, 0, 1, 0);
      send_frame(32'h0000_0001, 0, 1'b1, 1'b1, 1'b0, 1);
      chk("par_bad_valid", bus.instr_valid, 0);
      chk("par_bad_flag",  bus.parity_err, 1);
      chk("par_bad_ovr",   bus.overrun, 0);
      cyc(0, 0, 0, 1, 1);
      chk("par_clr", bus.parity_err, 0);
`endif

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         cyc(1'($urandom_range(1, 0)),
             ($urandom_range(3, 0) != 0),
             ($urandom_range(63, 0) == 0),
             1'($urandom_range(1, 0)),
             ($urandom_range(31, 0) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
